// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the floating-point adder arbiter.
//   add_state_e : adder status encoding (OK/NAN/INF/NUL)
//   tag_t       : requester-ID tag carried alongside each in-flight add
//   FP_W        : operand/result width
//   STAT_W      : width of one per-requester grant counter
//   ID_W        : tag ID width, sized for the largest supported N_REQ (8)
package fpu_arb_pkg;

   localparam int FP_W   = 32;
   localparam int STAT_W = 16;
   localparam int ID_W   = 3;

   typedef enum logic [1:0] {
      OK  = 2'b00,
      NAN = 2'b01,
      INF = 2'b10,
      NUL = 2'b11
   } add_state_e;

   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
   } tag_t;

   // Saturating increment for the grant statistics counters.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/fpu_add_arbiter_rr.sv
// Combinational round-robin arbiter.
// Grants the first asserted request found scanning ptr_i, ptr_i+1, ... mod N.
// Ports:
//   req_i      in  N   request vector
//   ptr_i      in  IW  index with highest priority this cycle
//   gnt_o      out N   one-hot grant (all zero when no request)
//   gnt_idx_o  out IW  index of the granted request (0 when none)
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] gnt_idx_o
);

   logic          found;
   logic [IW-1:0] idx;

   // NOTE: every variable written here gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         idx = IW'((int'(ptr_i) + k) % N);
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = idx;
         end
      end
   end

endmodule

// File: rtl/fpu_add_arbiter.sv
// Shares one pipelined floating-point adder between N_REQ requesters.
// One operand pair is issued per cycle in round-robin order; a tag pipe
// carrying the requester ID tracks each add so the result is routed back to
// the requester that issued it.
// Optional feature: define FPU_ARB_STATS_EN to build saturating per-requester
// grant counters; otherwise stat_grants is tied to zero.
// Ports:
//   clk, rst                   clock; asynchronous active-low reset
//   req_vld/req_a/req_b        per-requester operand valid and operands
//   req_rdy                    one-hot grant (combinational)
//   add_a/add_b/add_vld        issue to the adder
//   add_result/add_state/
//   add_res_vld                adder return
//   rsp_vld/rsp_result/
//   rsp_state                  one-hot response pulse with result and status
//   err_orphan                 sticky: adder result and tag pipe disagreed
//   stat_grants                per-requester grant counters, 16 bits each
module fpu_add_arbiter
   import fpu_arb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int LATENCY = 6,
   parameter int MAX_OUT = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_vld,
   input  logic [N_REQ*FP_W-1:0]   req_a,
   input  logic [N_REQ*FP_W-1:0]   req_b,
   output logic [N_REQ-1:0]        req_rdy,
   output logic [FP_W-1:0]         add_a,
   output logic [FP_W-1:0]         add_b,
   output logic                    add_vld,
   input  logic [FP_W-1:0]         add_result,
   input  logic [1:0]              add_state,
   input  logic                    add_res_vld,
   output logic [N_REQ-1:0]        rsp_vld,
   output logic [FP_W-1:0]         rsp_result,
   output logic [1:0]              rsp_state,
   output logic                    err_orphan,
   output logic [N_REQ*STAT_W-1:0] stat_grants
);

   localparam int IW = $clog2(N_REQ);
   localparam int OW = $clog2(MAX_OUT + 1);

   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] gnt;
   logic [IW-1:0]    gnt_idx;
   logic             hs;
   logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [OW-1:0]    out_q [N_REQ];
   logic [OW-1:0]    out_d [N_REQ];
   logic [FP_W-1:0]  add_a_q, add_b_q;
   // Stage 0 is the issue stage (valid alongside add_vld); the following
   // LATENCY stages mirror the adder, so the tail lines up with add_res_vld.
   tag_t             tag_q [LATENCY+1];
   tag_t             tail;
   logic [N_REQ-1:0] rsp_vld_q, rsp_vld_d;
   logic [FP_W-1:0]  rsp_result_q;
   add_state_e       rsp_state_q;
   logic             err_q;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         elig[i] = req_vld[i] && (out_q[i] < OW'(MAX_OUT));
      end
   end

   rr_arbiter #(.N(N_REQ)) u_rr (
      .req_i    (elig),
      .ptr_i    (rr_ptr_q),
      .gnt_o    (gnt),
      .gnt_idx_o(gnt_idx)
   );

   assign req_rdy = gnt;
   assign hs      = |gnt;
   assign tail    = tag_q[LATENCY];

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (hs) begin
         rr_ptr_d = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Outstanding count per requester: +1 on grant, -1 when its tag retires.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         out_d[i] = out_q[i];
         case ({hs && gnt[i],
                tail.vld && (tail.id == ID_W'(i)) && (out_q[i] != '0)})
            2'b10:   out_d[i] = out_q[i] + 1'b1;
            2'b01:   out_d[i] = out_q[i] - 1'b1;
            default: out_d[i] = out_q[i];
         endcase
         rsp_vld_d[i] = add_res_vld && tail.vld && (tail.id == ID_W'(i));
      end
   end

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples the pre-edge value of the others.
   // NOTE: the tag pipe and issue registers are reset, not just the valid
   // bits, because reset must leave add_a/add_b at zero and stale IDs would
   // otherwise survive into the next run.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q     <= '0;
         add_a_q      <= '0;
         add_b_q      <= '0;
         rsp_vld_q    <= '0;
         rsp_result_q <= '0;
         rsp_state_q  <= OK;
         err_q        <= 1'b0;
         for (int i = 0; i < N_REQ; i++) out_q[i] <= '0;
         for (int k = 0; k <= LATENCY; k++) tag_q[k] <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         for (int i = 0; i < N_REQ; i++) out_q[i] <= out_d[i];
         if (hs) begin
            add_a_q <= req_a[FP_W*gnt_idx +: FP_W];
            add_b_q <= req_b[FP_W*gnt_idx +: FP_W];
         end
         tag_q[0] <= '{vld: hs, id: ID_W'(gnt_idx)};
         for (int k = 1; k <= LATENCY; k++) tag_q[k] <= tag_q[k-1];
         rsp_vld_q <= rsp_vld_d;
         if (add_res_vld && tail.vld) begin
            rsp_result_q <= add_result;
            rsp_state_q  <= add_state_e'(add_state);
         end
         // A result without a tag is dropped; a tag without a result still
         // retires so the requester cannot hang. Either way it is an error.
         if (add_res_vld != tail.vld) err_q <= 1'b1;
      end
   end

   assign add_vld    = tag_q[0].vld;
   assign add_a      = add_a_q;
   assign add_b      = add_b_q;
   assign rsp_vld    = rsp_vld_q;
   assign rsp_result = rsp_result_q;
   assign rsp_state  = rsp_state_q;
   assign err_orphan = err_q;

`ifdef FPU_ARB_STATS_EN
   logic [STAT_W-1:0] stat_q [N_REQ];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_REQ; i++) stat_q[i] <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) stat_q[i] <= sat_inc(stat_q[i]);
         end
      end
   end

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat
      assign stat_grants[STAT_W*gi +: STAT_W] = stat_q[gi];
   end
`else
   assign stat_grants = '0;
`endif

endmodule
